sub_bytes_engine: RTL and testbench

Iterative, parametrised AES SubBytes/InvSubBytes unit. Accepts one AES state block over a valid/ready handshake and substitutes LANES bytes per clock through LANES forward/inverse S-box lanes. It returns the substituted block over a second valid/ready handshake. It sits between the round-key-add stage and ShiftRows in the round datapath, and is shared by the encrypt and decrypt paths through the per-block mode bit.

---
 rtl/aes_pkg.sv | 51 +++++
 rtl/sbox_lane.sv | 13 +
 rtl/sub_bytes_engine.sv | 108 ++++++++++
 tb/tb_sub_bytes_engine.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: engine FSM states, block width and the forward/inverse
// S-box byte tables.
package aes_pkg;

  localparam int AES_BLOCK_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/sbox_lane.sv
// One combinational S-box lane: forward or inverse byte substitution selected
// per block by the inverse bit.
module sbox_lane
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  input  logic       inverse,
  output logic [7:0] out_byte
);

  assign out_byte = inverse ? INV_SBOX[in_byte] : SBOX[in_byte];

endmodule

// File: rtl/sub_bytes_engine.sv
// Iterative AES SubBytes/InvSubBytes unit: substitutes LANES bytes of the held
// block per cycle, with valid/ready handshakes on both sides.
module sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int BLOCK_BYTES = AES_BLOCK_BYTES,
  parameter int LANES       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_inverse,
  input  logic [8*BLOCK_BYTES-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [8*BLOCK_BYTES-1:0] out_data,
  output logic                     busy
);

  localparam int GROUPS = BLOCK_BYTES / LANES;
  localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(GROUPS - 1);

  state_t                   state_q, state_d;
  logic [8*BLOCK_BYTES-1:0] work_q, work_d;
  logic                     mode_q, mode_d;
  logic [GRP_W-1:0]         grp_q, grp_d;
  logic [7:0]               lane_out [LANES];
  logic                     accept;
  logic                     last_grp;

  assign accept   = in_valid && in_ready;
  assign last_grp = (grp_q == LAST_GRP);

  // Lane k always works on byte grp*LANES+k; the same slice is written back below.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    sbox_lane u_lane (
      .in_byte  (work_q[(int'(grp_q) * LANES + k) * 8 +: 8]),
      .inverse  (mode_q),
      .out_byte (lane_out[k])
    );
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: default every output first so no path leaves a variable unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (last_grp) state_d = DONE;
      DONE: begin
        if (accept)         state_d = BUSY;
        else if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    out_valid = (state_q == DONE);
    busy      = (state_q == BUSY);
  end

  assign out_data = work_q;

  always_comb begin
    work_d = work_q;
    mode_d = mode_q;
    grp_d  = grp_q;
    if (accept) begin
      work_d = in_data;
      mode_d = in_inverse;
      grp_d  = '0;
    end else if (state_q == BUSY) begin
      for (int k = 0; k < LANES; k++) begin
        work_d[(int'(grp_q) * LANES + k) * 8 +: 8] = lane_out[k];
      end
      if (!last_grp) grp_d = grp_q + GRP_W'(1);
    end
  end

  // NOTE: the block register is cleared on reset so a discarded partial block
  // never appears on out_data; it is a register bank, not a RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_q <= '0;
      mode_q <= 1'b0;
      grp_q  <= '0;
    end else begin
      work_q <= work_d;
      mode_q <= mode_d;
      grp_q  <= grp_d;
    end
  end

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Self-checking bench for sub_bytes_engine: GF(2^8)-derived S-box model, a
// per-cycle handshake model, directed vectors and a LANES sweep.
module tb_sub_bytes_engine;

  localparam int NB     = 16;
  localparam int GROUPS = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid, in_ready, in_inverse, out_valid, out_ready, busy;
  logic [8*NB-1:0] in_data, out_data;

  logic            sw_in_valid;
  logic [8*NB-1:0] sw_in_data;
  logic            sw_in_ready [3];
  logic            sw_out_valid [3];
  logic            sw_busy [3];
  logic [8*NB-1:0] sw_out_data [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sub_bytes_engine #(.BLOCK_BYTES(NB), .LANES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inverse(in_inverse), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  sub_bytes_engine #(.BLOCK_BYTES(NB), .LANES(1)) dut_l1 (
    .clk(clk), .rst(rst), .in_valid(sw_in_valid), .in_ready(sw_in_ready[0]),
    .in_inverse(1'b0), .in_data(sw_in_data), .out_valid(sw_out_valid[0]),
    .out_ready(1'b1), .out_data(sw_out_data[0]), .busy(sw_busy[0])
  );

  sub_bytes_engine #(.BLOCK_BYTES(NB), .LANES(2)) dut_l2 (
    .clk(clk), .rst(rst), .in_valid(sw_in_valid), .in_ready(sw_in_ready[1]),
    .in_inverse(1'b0), .in_data(sw_in_data), .out_valid(sw_out_valid[1]),
    .out_ready(1'b1), .out_data(sw_out_data[1]), .busy(sw_busy[1])
  );

  sub_bytes_engine #(.BLOCK_BYTES(NB), .LANES(16)) dut_l16 (
    .clk(clk), .rst(rst), .in_valid(sw_in_valid), .in_ready(sw_in_ready[2]),
    .in_inverse(1'b0), .in_data(sw_in_data), .out_valid(sw_out_valid[2]),
    .out_ready(1'b1), .out_data(sw_out_data[2]), .busy(sw_busy[2])
  );

  task automatic check(input string name, input logic [8*NB-1:0] act, input logic [8*NB-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // S-box model from field arithmetic: multiplicative inverse then affine map.
  logic [7:0] m_sbox [256];
  logic [7:0] m_inv  [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, base;
    int e;
    r = 8'h01; base = a; e = 254;
    while (e != 0) begin
      if (e % 2 == 1) r = gmul(r, base);
      base = gmul(base, base);
      e = e / 2;
    end
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [8*NB-1:0] sub_block(input logic [8*NB-1:0] d, input logic inv);
    logic [8*NB-1:0] r;
    for (int i = 0; i < NB; i++) r[8*i +: 8] = inv ? m_inv[d[8*i +: 8]] : m_sbox[d[8*i +: 8]];
    return r;
  endfunction

  // Handshake model: a block takes GROUPS edges, then is offered until taken.
  int              m_left;
  bit              m_done;
  logic [8*NB-1:0] m_pend, m_out;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0;
      m_done = 1'b0;
      m_out  = '0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_done = 1'b1;
        m_out  = m_pend;
      end
    end else if (in_valid && (!m_done || out_ready)) begin
      m_pend = sub_block(in_data, in_inverse);
      m_left = GROUPS;
      m_done = 1'b0;
    end else if (m_done && out_ready) begin
      m_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    #3;
    if (!rst) begin
      check("in_ready", 128'(in_ready), 128'((m_left == 0) && (!m_done || out_ready)));
      check("out_valid", 128'(out_valid), 128'(m_done));
      check("busy", 128'(busy), 128'(m_left > 0));
      if (m_done) check("out_data", out_data, m_out);
    end
  end

  // Presents one block; returns its result, latency in cycles and busy count.
  task automatic run_block(input logic [8*NB-1:0] data, input logic inv, input int hold,
                           output logic [8*NB-1:0] res, output int lat, output int bcnt);
    in_valid = 1'b1; in_data = data; in_inverse = inv; out_ready = 1'b1;
    #1;
    check("in_ready_at_present", 128'(in_ready), 128'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_inverse = ~inv;
    in_data = {$urandom, $urandom, $urandom, $urandom};
    out_ready = (hold == 0);
    #1;
    check("busy_after_accept", 128'(busy), 128'(1));
    check("no_valid_after_accept", 128'(out_valid), 128'(0));
    lat = 0; bcnt = 0;
    while (!out_valid && lat < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      #1;
      lat++;
    end
    res = out_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      #1;
      check("hold_data", out_data, res);
      check("hold_valid", 128'(out_valid), 128'(1));
      check("hold_in_ready", 128'(in_ready), 128'(0));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [8*NB-1:0] res, mixed, mixed_sub, zeros, all63, data;
    int lat, bcnt;
    int first [3];
    logic [8*NB-1:0] sres [3];

    rst = 1'b1; in_valid = 1'b0; in_inverse = 1'b0; in_data = '0; out_ready = 1'b1;
    sw_in_valid = 1'b0; sw_in_data = '0;

    for (int i = 0; i < 256; i++) m_sbox[i] = affine(ginv(8'(i)));
    for (int i = 0; i < 256; i++) m_inv[m_sbox[i]] = 8'(i);

    check("model_s00", 128'(m_sbox[8'h00]), 128'(8'h63));
    check("model_s11", 128'(m_sbox[8'h11]), 128'(8'h82));
    check("model_s53", 128'(m_sbox[8'h53]), 128'(8'hed));
    check("model_inv63", 128'(m_inv[8'h63]), 128'(8'h00));

    zeros = '0;
    all63 = {NB{8'h63}};
    mixed = {{12{8'h00}}, 8'h53, 8'h23, 8'h22, 8'h11};
    mixed_sub = {{12{8'h63}}, 8'hed, 8'h26, 8'h93, 8'h82};

    #12 rst = 1'b0;
    @(negedge clk);
    #1;
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_out_data", out_data, zeros);

    run_block(zeros, 1'b0, 0, res, lat, bcnt);
    check("zero_fwd_data", res, all63);
    check("zero_fwd_latency", 128'(lat), 128'(4));
    check("zero_fwd_busy_cycles", 128'(bcnt), 128'(4));

    run_block(mixed, 1'b0, 0, res, lat, bcnt);
    check("mixed_fwd_data", res, mixed_sub);
    check("mixed_fwd_latency", 128'(lat), 128'(4));

    run_block(mixed_sub, 1'b1, 0, res, lat, bcnt);
    check("mixed_inv_data", res, mixed);

    @(negedge clk);
    run_block(mixed, 1'b0, 10, res, lat, bcnt);
    check("bp_data", res, mixed_sub);
    run_block(all63, 1'b1, 0, res, lat, bcnt);
    check("bp_next_inv_data", res, zeros);
    check("bp_next_latency", 128'(lat), 128'(4));

    @(negedge clk);
    in_valid = 1'b1; in_data = mixed; in_inverse = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_in_ready", 128'(in_ready), 128'(1));
    check("midrst_out_valid", 128'(out_valid), 128'(0));
    check("midrst_busy", 128'(busy), 128'(0));
    check("midrst_out_data", out_data, zeros);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    run_block(mixed, 1'b0, 0, res, lat, bcnt);
    check("post_rst_data", res, mixed_sub);
    check("post_rst_latency", 128'(lat), 128'(4));

    for (int b = 0; b < 16; b++) begin
      for (int i = 0; i < NB; i++) data[8*i +: 8] = 8'(b * 16 + i);
      run_block(data, 1'b0, 0, res, lat, bcnt);
      check("table_fwd", res, sub_block(data, 1'b0));
      run_block(data, 1'b1, 0, res, lat, bcnt);
      check("table_inv", res, sub_block(data, 1'b1));
    end

    @(negedge clk);
    for (int j = 0; j < 3; j++) check("sweep_in_ready", 128'(sw_in_ready[j]), 128'(1));
    sw_in_valid = 1'b1; sw_in_data = zeros;
    @(posedge clk);
    @(negedge clk);
    sw_in_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      first[j] = -1;
      sres[j] = '0;
    end
    for (int k = 0; k <= 24; k++) begin
      #1;
      for (int j = 0; j < 3; j++) begin
        if (first[j] < 0 && sw_out_valid[j]) begin
          first[j] = k;
          sres[j] = sw_out_data[j];
        end
      end
      @(negedge clk);
    end
    check("sweep_l1_latency", 128'(first[0]), 128'(16));
    check("sweep_l2_latency", 128'(first[1]), 128'(8));
    check("sweep_l16_latency", 128'(first[2]), 128'(1));
    for (int j = 0; j < 3; j++) check("sweep_data", sres[j], all63);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
